// File: rtl/key_debouncer.sv
// Per-key 2-flop sync + consecutive-sample debounce; clean level, pressed level, press/release pulses.
// Latency: raw change at edge E1 appears at edge E(DEBOUNCE_CYCLES+2); no backpressure (free-running).
module key_debouncer #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_export,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [NUM_KEYS-1:0] key_release_pulse
);

  localparam int                  CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] IDLE     = ACTIVE_LOW ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_stable;
  logic [NUM_KEYS-1:0] r_press_pulse;
  logic [NUM_KEYS-1:0] r_release_pulse;
  logic [CW-1:0]       r_cnt [NUM_KEYS];

  state_t              w_state      [NUM_KEYS];
  logic [CW-1:0]       w_cnt_nxt    [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_stable_nxt;
  logic [NUM_KEYS-1:0] w_press_nxt;
  logic [NUM_KEYS-1:0] w_release_nxt;

  // A key is COUNTING whenever its synchronised sample disagrees with the accepted level.
  always_comb begin
    w_stable_nxt  = r_stable;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_state[i]   = (r_sync2[i] != r_stable[i]) ? ST_COUNTING : ST_STABLE;
      w_cnt_nxt[i] = '0;
      case (w_state[i])
        ST_STABLE: w_cnt_nxt[i] = '0;
        ST_COUNTING: begin
          if (r_cnt[i] == CNT_LAST) begin
            w_stable_nxt[i] = r_sync2[i];
            if (r_sync2[i] != IDLE[i]) w_press_nxt[i] = 1'b1;
            else                       w_release_nxt[i] = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
          end
        end
        default: w_cnt_nxt[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1         <= IDLE;
      r_sync2         <= IDLE;
      r_stable        <= IDLE;
      r_press_pulse   <= '0;
      r_release_pulse <= '0;
      for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1         <= keys_raw;
      r_sync2         <= r_sync1;
      r_stable        <= w_stable_nxt;
      r_press_pulse   <= w_press_nxt;
      r_release_pulse <= w_release_nxt;
      for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign keys_export       = r_stable;
  assign key_pressed       = r_stable ^ IDLE;
  assign key_press_pulse   = r_press_pulse;
  assign key_release_pulse = r_release_pulse;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: an active-low and an active-high instance share one pressed-domain stimulus
// and are compared every cycle against a sample-window model, plus literal checks on directed scenarios.
module tb_key_debouncer;

  localparam int NK = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] press_in = '0;
  logic [NK-1:0] raw_lo, raw_hi;
  logic [NK-1:0] lo_exp, lo_prs, lo_pp, lo_rp;
  logic [NK-1:0] hi_exp, hi_prs, hi_pp, hi_rp;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  assign raw_lo = ~press_in;
  assign raw_hi = press_in;

  always #5 clk = ~clk;

  key_debouncer #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk_clk(clk), .reset_reset(rst), .keys_raw(raw_lo), .keys_export(lo_exp),
    .key_pressed(lo_prs), .key_press_pulse(lo_pp), .key_release_pulse(lo_rp));

  key_debouncer #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk_clk(clk), .reset_reset(rst), .keys_raw(raw_hi), .keys_export(hi_exp),
    .key_pressed(hi_prs), .key_press_pulse(hi_pp), .key_release_pulse(hi_rp));

  // Model in the "pressed" domain: accept a new level once the last DC synchronised samples all disagree.
  bit [NK-1:0] m_s1, m_s2, m_pressed, m_pp, m_rp;
  bit          m_hist [NK][DC];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_pressed = '0; m_pp = '0; m_rp = '0;
      for (int k = 0; k < NK; k++)
        for (int j = 0; j < DC; j++) m_hist[k][j] = 1'b0;
    end else begin
      m_pp = '0; m_rp = '0;
      for (int k = 0; k < NK; k++) begin
        bit all_diff;
        for (int j = DC - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = m_s2[k];
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++) if (m_hist[k][j] == m_pressed[k]) all_diff = 1'b0;
        if (all_diff) begin
          m_pressed[k] = ~m_pressed[k];
          if (m_pressed[k]) m_pp[k] = 1'b1;
          else              m_rp[k] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = press_in;
    end
  end

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lo_export",  lo_exp, ~m_pressed);
      chk("lo_pressed", lo_prs, m_pressed);
      chk("lo_press",   lo_pp,  m_pp);
      chk("lo_release", lo_rp,  m_rp);
      chk("hi_export",  hi_exp, m_pressed);
      chk("hi_pressed", hi_prs, m_pressed);
      chk("hi_press",   hi_pp,  m_pp);
      chk("hi_release", hi_rp,  m_rp);
      chk("both_pulses", (lo_pp & lo_rp) | (hi_pp & hi_rp), '0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string name, input logic [NK-1:0] pp, input logic [NK-1:0] rp);
    chk({name, "_lo_pp"}, lo_pp, pp);
    chk({name, "_hi_pp"}, hi_pp, pp);
    chk({name, "_model_pp"}, m_pp, pp);
    chk({name, "_lo_rp"}, lo_rp, rp);
    chk({name, "_hi_rp"}, hi_rp, rp);
    chk({name, "_model_rp"}, m_rp, rp);
  endtask

  initial begin
    int hold [NK];
    int npulse;

    // Reset held three cycles with keys idle.
    rst = 1'b1; press_in = '0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk_en = 1'b1;
      chk("rst_lo_export", lo_exp, 2'b11);
      chk("rst_hi_export", hi_exp, 2'b00);
      chk("rst_pressed", lo_prs | hi_prs, 2'b00);
      chk_pulses("rst", 2'b00, 2'b00);
    end
    rst = 1'b0;
    step(3);
    chk("post_rst_lo_export", lo_exp, 2'b11);
    chk_pulses("post_rst", 2'b00, 2'b00);

    // Clean press on key 0: accepted at edge E6.
    press_in[0] = 1'b1;
    step(5);
    chk("press_e5_pressed", lo_prs, 2'b00);
    chk_pulses("press_e5", 2'b00, 2'b00);
    step(1);
    chk("press_e6_lo_export", lo_exp, 2'b10);
    chk("press_e6_pressed", lo_prs, 2'b01);
    chk("press_e6_model", m_pressed, 2'b01);
    chk_pulses("press_e6", 2'b01, 2'b00);
    step(1);
    chk("press_e7_pressed", hi_prs, 2'b01);
    chk_pulses("press_e7", 2'b00, 2'b00);

    // Three-cycle glitch on key 1 is rejected.
    press_in[1] = 1'b1;
    step(3);
    press_in[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      chk("glitch_lo_export", lo_exp, 2'b10);
      chk_pulses("glitch", 2'b00, 2'b00);
    end

    // Release key 0, then bounce 1,0,1,0 and settle pressed.
    press_in[0] = 1'b0;
    step(8);
    chk("rel0_pressed", lo_prs, 2'b00);
    press_in[0] = 1'b1; step(1);
    press_in[0] = 1'b0; step(1);
    press_in[0] = 1'b1; step(1);
    press_in[0] = 1'b0; step(1);
    press_in[0] = 1'b1;
    npulse = 0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      npulse += int'(lo_pp[0]);
      if (c == 6) chk_pulses("bounce_e6", 2'b01, 2'b00);
      else        chk_pulses("bounce", 2'b00, 2'b00);
    end
    chk("bounce_pulse_count", 2'(npulse), 2'd1);

    // Press key 1 too, then release both together.
    press_in[1] = 1'b1;
    step(8);
    chk("both_pressed", lo_prs, 2'b11);
    press_in = 2'b00;
    step(5);
    chk_pulses("simul_e5", 2'b00, 2'b00);
    step(1);
    chk_pulses("simul_e6", 2'b00, 2'b11);
    chk("simul_lo_export", lo_exp, 2'b11);
    chk("simul_hi_export", hi_exp, 2'b00);
    step(1);
    chk_pulses("simul_e7", 2'b00, 2'b00);

    // Reset after two counting edges; key still held afterwards counts as a new press.
    press_in[0] = 1'b1;
    step(4);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1);
      chk("midrst_lo_export", lo_exp, 2'b11);
      chk("midrst_pressed", lo_prs | hi_prs, 2'b00);
      chk_pulses("midrst", 2'b00, 2'b00);
    end
    rst = 1'b0;
    step(5);
    chk_pulses("after_rst_e5", 2'b00, 2'b00);
    step(1);
    chk_pulses("after_rst_e6", 2'b01, 2'b00);
    chk("after_rst_pressed", hi_prs, 2'b01);
    press_in = 2'b00;
    step(8);

    // Randomised stimulus: mixes short bounces with long holds and occasional resets.
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          press_in[k] = 1'($urandom_range(0, 1));
          hold[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 14))
                                                : int'($urandom_range(1, 3));
        end
        hold[k]--;
      end
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
